spatz_ipu_sequencer: RTL
========================

Name: spatz_ipu_sequencer

Overview:
Upstream issue stage of the integer processing unit (IPU). Accepts one vector arithmetic request (operation, SEW, vl), streams ELEN-wide operand words from the VRF read path into the IPU through a registered issue stage, and buffers the IPU results in a small FIFO. Results leave the FIFO with tail-masked byte enables and a last flag towards VRF writeback.

Parameters:
- ELEN, 32, datapath width in bits; ELENB = ELEN/8.
- VlWidth, 16, width of the vl field in elements.
- ResFifoDepth, 2, result FIFO entries (>=2, power of two).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_op_i  in  op_e  operation
- req_sew_i  in  rvv_pkg::vew_e  element width (EW_8/EW_16/EW_32)
- req_vl_i  in  VlWidth  element count
- opnd_valid_i  in  1  operand word valid
- opnd_ready_o  out  1  operand word accepted
- opnd_s1_i, opnd_s2_i, opnd_d_i  in  ELEN each  operand words
- opnd_carry_i  in  ELENB  per-element carry bits (LSB-aligned)
- ipu_operation_o  out  op_e  to IPU
- ipu_sew_o  out  vew_e  to IPU
- ipu_op_s1_o, ipu_op_s2_o, ipu_op_d_o  out  ELEN each  to IPU
- ipu_carry_o  out  ELENB  to IPU
- ipu_result_i  in  ELEN  IPU result (combinational from ipu_* outputs)
- ipu_be_i  in  ELENB  IPU byte enables
- res_valid_o  out  1  result word valid
- res_ready_i  in  1  result consumed
- res_o  out  ELEN  result word
- res_be_o  out  ELENB  byte enables
- res_last_o  out  1  final word of request
- busy_o  out  1  request in flight

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous, active-low. All outputs 0 in reset; FSM in IDLE, FIFO empty, counters 0.
- FSM IDLE/ISSUE/DRAIN. IDLE: req_ready_o=1; on accept latch op, sew, vl; words = ceil(vl*bytes(sew)/ELENB); vl=0 -> stay IDLE, no result produced; else -> ISSUE.
- ISSUE: opnd_ready_o = !issue_valid || issue_fire. Accepted word loads issue register (op, sew, operands, carry, tail mask, last flag); word counter decrements. After last word accepted -> DRAIN.
- issue_fire = issue_valid && FIFO not full; pushes {ipu_result_i, ipu_be_i & tail_mask, last} into FIFO, same cycle.
- DRAIN: wait until issue register empty and last entry popped (res_valid_o && res_ready_i && res_last_o) -> IDLE. New request not accepted before then.
- ipu_operation_o/ipu_sew_o hold latched values for the whole request; ipu_op_*/ipu_carry_o from issue register, 0 when empty.
- Latency: operand accepted in cycle N -> res_valid_o in cycle N+2 with no backpressure. Full throughput one word/cycle.
- Tail mask: all ones except on last word, where only bytes (vl*bytes(sew)) mod ELENB are set (all ones when remainder 0). Elements per word 4/2/1 for EW_8/16/32.
- FIFO full: issue register holds, opnd_ready_o=0; no data loss. Simultaneous push and pop on full FIFO is allowed.
- res_* show FIFO head; stable while res_valid_o && !res_ready_i.
- busy_o = state != IDLE.
- Reset mid-request: all in-flight words discarded, FSM to IDLE.

Optional Feature:
SPATZ_IPU_SEQ_PERF_EN: adds output stall_cnt_o (32 bits), counting cycles with issue_valid && FIFO full, cleared on request accept, saturating at all ones. Without the macro the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- EW_32, vl=3, operands always valid, res_ready_i=1 -> 3 results, first res_valid_o 2 cycles after first operand accept, be=4'hF each, res_last_o on 3rd.
- EW_8, vl=6 -> 2 words; word0 be=4'hF, word1 be=4'h3 with res_last_o.
- EW_16, vl=0 -> request accepted, busy_o stays 0, no res_valid_o, next request accepted next cycle.
- res_ready_i=0 for 10 cycles during EW_32 vl=8 -> FIFO holds 2 and issue reg holds 1; opnd_ready_o=0; all 8 results delivered in order afterwards.
- opnd_carry_i=4'b1010 with EW_8 VADC -> ipu_carry_o=4'b1010 while the word is in the issue register.
- rst_ni low mid-request (EW_32, vl=4, after 2 results) -> outputs 0 immediately, busy_o=0; new request runs cleanly.

Source files
------------

// File: rtl/spatz_ipu_sequencer.sv
// IPU issue sequencer: streams operand words through a registered issue stage into the IPU
// and queues the results for VRF writeback. Optional stall counter: SPATZ_IPU_SEQ_PERF_EN.

package rvv_pkg;
    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

    typedef enum logic [2:0] {
        VADD = 3'd0,
        VSUB = 3'd1,
        VADC = 3'd2,
        VSBC = 3'd3,
        VAND = 3'd4,
        VOR  = 3'd5,
        VXOR = 3'd6,
        VMUL = 3'd7
    } op_e;
endpackage

module spatz_ipu_res_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed once a push has written them.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end
endmodule

module spatz_ipu_sequencer
    import rvv_pkg::*;
#(
    parameter int unsigned ELEN         = 32,
    parameter int unsigned VlWidth      = 16,
    parameter int unsigned ResFifoDepth = 2,
    localparam int unsigned ELENB       = ELEN / 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  op_e                req_op_i,
    input  vew_e               req_sew_i,
    input  logic [VlWidth-1:0] req_vl_i,
    input  logic               opnd_valid_i,
    output logic               opnd_ready_o,
    input  logic [ELEN-1:0]    opnd_s1_i,
    input  logic [ELEN-1:0]    opnd_s2_i,
    input  logic [ELEN-1:0]    opnd_d_i,
    input  logic [ELENB-1:0]   opnd_carry_i,
    output op_e                ipu_operation_o,
    output vew_e               ipu_sew_o,
    output logic [ELEN-1:0]    ipu_op_s1_o,
    output logic [ELEN-1:0]    ipu_op_s2_o,
    output logic [ELEN-1:0]    ipu_op_d_o,
    output logic [ELENB-1:0]   ipu_carry_o,
    input  logic [ELEN-1:0]    ipu_result_i,
    input  logic [ELENB-1:0]   ipu_be_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [ELEN-1:0]    res_o,
    output logic [ELENB-1:0]   res_be_o,
    output logic               res_last_o,
`ifdef SPATZ_IPU_SEQ_PERF_EN
    output logic [31:0]        stall_cnt_o,
`endif
    output logic               busy_o
);
    localparam int unsigned BW = $clog2(ELENB);
    localparam int unsigned CW = VlWidth + 3;
    localparam int unsigned FW = ELEN + ELENB + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    typedef struct packed {
        logic [ELEN-1:0]  res;
        logic [ELENB-1:0] be;
        logic             last;
    } res_entry_t;

    state_e state_q, state_d;

    op_e             op_q;
    vew_e            sew_q;
    logic [BW-1:0]   rem_q;
    logic [CW-1:0]   cnt_q;

    logic            req_fire, opnd_fire, opnd_last, issue_fire, res_pop;
    logic [CW-1:0]   req_bytes, req_words;
    logic [ELENB-1:0] tail_mask;

    logic             iss_vld_q, iss_last_q;
    logic [ELEN-1:0]  iss_s1_q, iss_s2_q, iss_d_q;
    logic [ELENB-1:0] iss_carry_q, iss_mask_q;

    res_entry_t       push_entry, head_entry;
    logic [FW-1:0]    head_raw;
    logic             fifo_empty, fifo_full;

    // Total bytes of the request, then rounded up to whole ELEN words.
    assign req_bytes = CW'(req_vl_i) << req_sew_i;
    assign req_words = (req_bytes + CW'(ELENB - 1)) >> BW;

    assign req_fire   = req_valid_i && req_ready_o;
    assign opnd_fire  = opnd_valid_i && opnd_ready_o;
    assign opnd_last  = (cnt_q == CW'(1));
    assign issue_fire = iss_vld_q && !fifo_full;
    assign res_pop    = res_valid_o && res_ready_i;

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        opnd_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0 in reset.
                req_ready_o = rst_ni;
                if (req_fire && (req_vl_i != '0)) state_d = ISSUE;
            end
            ISSUE: begin
                opnd_ready_o = !iss_vld_q || issue_fire;
                if (opnd_fire && opnd_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!iss_vld_q && res_pop && res_last_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= VADD;
            sew_q <= EW_8;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (req_fire) begin
            op_q  <= req_op_i;
            sew_q <= req_sew_i;
            rem_q <= req_bytes[BW-1:0];
            cnt_q <= req_words;
        end else if (opnd_fire) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Only the final word is trimmed; a zero remainder means the last word is full.
    for (genvar b = 0; b < ELENB; b++) begin : g_tail
        assign tail_mask[b] = !opnd_last || (rem_q == '0) || (BW'(b) < rem_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_vld_q   <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_s1_q    <= '0;
            iss_s2_q    <= '0;
            iss_d_q     <= '0;
            iss_carry_q <= '0;
            iss_mask_q  <= '0;
        end else if (opnd_fire) begin
            iss_vld_q   <= 1'b1;
            iss_last_q  <= opnd_last;
            iss_s1_q    <= opnd_s1_i;
            iss_s2_q    <= opnd_s2_i;
            iss_d_q     <= opnd_d_i;
            iss_carry_q <= opnd_carry_i;
            iss_mask_q  <= tail_mask;
        end else if (issue_fire) begin
            iss_vld_q   <= 1'b0;
        end
    end

    assign ipu_operation_o = op_q;
    assign ipu_sew_o       = sew_q;
    assign ipu_op_s1_o     = iss_vld_q ? iss_s1_q    : '0;
    assign ipu_op_s2_o     = iss_vld_q ? iss_s2_q    : '0;
    assign ipu_op_d_o      = iss_vld_q ? iss_d_q     : '0;
    assign ipu_carry_o     = iss_vld_q ? iss_carry_q : '0;

    assign push_entry.res  = ipu_result_i;
    assign push_entry.be   = ipu_be_i & iss_mask_q;
    assign push_entry.last = iss_last_q;

    spatz_ipu_res_fifo #(
        .Width (FW),
        .Depth (ResFifoDepth)
    ) i_res_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue_fire),
        .data_i  (push_entry),
        .pop_i   (res_pop),
        .data_o  (head_raw),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign head_entry  = res_entry_t'(head_raw);
    assign res_valid_o = !fifo_empty;
    assign res_o       = fifo_empty ? '0 : head_entry.res;
    assign res_be_o    = fifo_empty ? '0 : head_entry.be;
    assign res_last_o  = !fifo_empty && head_entry.last;
    assign busy_o      = (state_q != IDLE);

`ifdef SPATZ_IPU_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   stall_cnt_q <= '0;
        else if (req_fire)                             stall_cnt_q <= '0;
        else if (iss_vld_q && fifo_full && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
